// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch path.
//   XLEN      : architectural register / instruction width
//   HALT_INSN : encoding that stops instruction fetch
//   NOP_INSN  : canonical no-op (addi x0, x0, 0)
//   fetch_state_e : fetch-engine state (RUN, HALTED)
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] HALT_INSN = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] NOP_INSN  = 32'h0000_0013;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_memory_imem_array.sv
// Instruction storage: DEPTH x DATA_WIDTH words, one synchronous write port and
// one synchronous read-first read port. Storage is never reset; only the read
// output register is cleared by reset_n.
//   clk, reset_n      : clock, async active-low reset (read register only)
//   we, waddr, wdata  : write port, commits on the rising edge
//   re, raddr         : read enable / word index; rdata updates only when re=1
//   rdata             : registered read data (old word on same-edge write)
module imem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read samples the array before this edge's write lands: read-first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instruction_fetch_memory.sv
// Clocked instruction memory between the PC/fetch stage and decode.
// Fetches use a valid/ready request and a registered, backpressurable response.
// Faults are flagged for misaligned or out-of-range byte addresses; a halt word
// that is consumed stops fetch until a resume pulse.
//   clk, reset_n                         : clock, async active-low reset
//   req_valid, req_ready, req_addr       : fetch request (byte address)
//   resp_valid, resp_ready               : response handshake
//   resp_instr, resp_fault, resp_halt    : response payload
//   prog_we, prog_addr, prog_data        : run-time program load port
//   resume, halted                       : leave HALTED / HALTED status
//   fetch_count                          : saturating count of accepted requests
module instruction_fetch_memory
   import riscv_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          DEPTH      = 256,
   parameter int unsigned          ADDR_WIDTH = 10,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD = HALT_INSN,
   localparam int unsigned         IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_instr,
   output logic                  resp_fault,
   output logic                  resp_halt,
   input  logic                  prog_we,
   input  logic [IDX_W-1:0]      prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   input  logic                  resume,
   output logic                  halted,
   output logic [15:0]           fetch_count
);

   // DEPTH fits in ADDR_WIDTH bits because 2^ADDR_WIDTH >= 4*DEPTH.
   localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);

   fetch_state_e          state_q, state_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  fault_q, fault_d;
   logic [15:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  req_accept;
   logic                  resp_accept;
   logic                  req_fault;
   logic [ADDR_WIDTH-1:0] word_index;

   // Full-width index so addresses beyond the array never alias onto it.
   assign word_index = {2'b00, req_addr[ADDR_WIDTH-1:2]};
   assign req_fault  = (req_addr[1:0] != 2'b00) || (word_index >= DEPTH_LIMIT);

   assign req_ready   = (state_q == RUN) && (!resp_valid_q || resp_ready);
   assign req_accept  = req_valid && req_ready;
   assign resp_accept = resp_valid_q && resp_ready;

   imem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_imem_array (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (prog_we),
      .waddr   (prog_addr),
      .wdata   (prog_data),
      .re      (req_accept),
      .raddr   (req_addr[IDX_W+1:2]),
      .rdata   (rdata)
   );

   // rdata and fault_q only move on acceptance, so the payload holds under stall.
   assign resp_valid  = resp_valid_q;
   assign resp_fault  = fault_q;
   assign resp_instr  = fault_q ? '0 : rdata;
   assign resp_halt   = !fault_q && (rdata == HALT_WORD);
   assign halted      = (state_q == HALTED);
   assign fetch_count = count_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            // A resume on the same edge as the halt response keeps us running.
            if (resp_accept && resp_halt && !resume) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            if (resume) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      resp_valid_d = resp_valid_q;
      fault_d      = fault_q;
      count_d      = count_q;
      if (req_accept) begin
         resp_valid_d = 1'b1;
         fault_d      = req_fault;
         if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
         end
      end else if (resp_accept) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RUN;
         resp_valid_q <= 1'b0;
         fault_q      <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         fault_q      <= fault_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_memory.sv
module tb_instruction_fetch_memory;

   localparam int unsigned DW = 32;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW = 11;
   localparam int unsigned IW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_instr;
   logic          resp_fault;
   logic          resp_halt;
   logic          prog_we = 1'b0;
   logic [IW-1:0] prog_addr = '0;
   logic [DW-1:0] prog_data = '0;
   logic          resume = 1'b0;
   logic          halted;
   logic [15:0]   fetch_count;

   int n_vec = 0;
   int n_err = 0;

   instruction_fetch_memory #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .HALT_WORD  (32'hFFFF_FFFF)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_instr  (resp_instr),
      .resp_fault  (resp_fault),
      .resp_halt   (resp_halt),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .resume      (resume),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then sit 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      n_vec++; if (resp_instr !== 32'h0) begin n_err++; $display("FAIL reset_resp_instr got %h want 0", resp_instr); end
      n_vec++; if (resp_fault !== 1'b0 || resp_halt !== 1'b0) begin n_err++; $display("FAIL reset_fault_halt got %b%b want 00", resp_fault, resp_halt); end
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
      n_vec++; if (fetch_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fetch_count); end
      #4 reset_n = 1'b1;
      step();
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
   endtask

   task automatic test_program();
      logic [DW-1:0] words [3];
      words[0] = 32'h3e80_0293;
      words[1] = 32'h0051_2023;
      words[2] = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         prog_we   = 1'b1;
         prog_addr = IW'(i);
         prog_data = words[i];
         step();
      end
      prog_we = 1'b0;
   endtask

   task automatic test_fetch_halt();
      logic [DW-1:0] exp [3];
      exp[0] = 32'h3e80_0293;
      exp[1] = 32'h0051_2023;
      exp[2] = 32'hFFFF_FFFF;
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_addr = AW'(4 * i);
         step();
         if (i == 2) req_valid = 1'b0;
         n_vec++; if (resp_valid !== 1'b1 || resp_instr !== exp[i]) begin n_err++; $display("FAIL seq_fetch%0d got v=%b %h want v=1 %h", i, resp_valid, resp_instr, exp[i]); end
         n_vec++; if (resp_halt !== (i == 2)) begin n_err++; $display("FAIL seq_halt%0d got %b want %b", i, resp_halt, (i == 2)); end
      end
      step();
      n_vec++; if (halted !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL halt_entry got halted=%b ready=%b want 1 0", halted, req_ready); end
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL halt_drain got %b want 0", resp_valid); end
      n_vec++; if (fetch_count !== 16'd3) begin n_err++; $display("FAIL halt_count got %0d want 3", fetch_count); end
   endtask

   task automatic test_halted_resume();
      req_valid = 1'b1;
      req_addr  = '0;
      step();
      step();
      n_vec++; if (resp_valid !== 1'b0 || fetch_count !== 16'd3) begin n_err++; $display("FAIL halted_block got v=%b cnt=%0d want 0 3", resp_valid, fetch_count); end
      resume = 1'b1;
      step();
      resume = 1'b0;
      n_vec++; if (req_ready !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL resume got ready=%b halted=%b want 1 0", req_ready, halted); end
      step();
      req_valid = 1'b0;
      n_vec++; if (resp_valid !== 1'b1 || resp_instr !== 32'h3e80_0293) begin n_err++; $display("FAIL resume_fetch got v=%b %h want 1 3e800293", resp_valid, resp_instr); end
      n_vec++; if (fetch_count !== 16'd4) begin n_err++; $display("FAIL resume_count got %0d want 4", fetch_count); end
      step();
      n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL resume_drain got %b want 0", resp_valid); end
   endtask

   task automatic test_backpressure();
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = AW'(4);
      step();
      req_addr = '0;
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (resp_valid !== 1'b1 || resp_instr !== 32'h0051_2023) begin n_err++; $display("FAIL bp_hold%0d got v=%b %h want 1 00512023", i, resp_valid, resp_instr); end
         n_vec++; if (req_ready !== 1'b0 || fetch_count !== 16'd5) begin n_err++; $display("FAIL bp_stall%0d got ready=%b cnt=%0d want 0 5", i, req_ready, fetch_count); end
         step();
      end
      resp_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", req_ready); end
      step();
      req_valid = 1'b0;
      n_vec++; if (resp_valid !== 1'b1 || resp_instr !== 32'h3e80_0293 || fetch_count !== 16'd6) begin n_err++; $display("FAIL bp_b2b got v=%b %h cnt=%0d want 1 3e800293 6", resp_valid, resp_instr, fetch_count); end
      step();
   endtask

   task automatic test_faults();
      req_valid = 1'b1;
      req_addr  = AW'(2);
      step();
      n_vec++; if (resp_fault !== 1'b1 || resp_instr !== 32'h0 || resp_halt !== 1'b0) begin n_err++; $display("FAIL fault_misalign got f=%b %h h=%b want 1 0 0", resp_fault, resp_instr, resp_halt); end
      n_vec++; if (fetch_count !== 16'd7) begin n_err++; $display("FAIL fault_count1 got %0d want 7", fetch_count); end
      req_addr = AW'(1024);
      step();
      req_valid = 1'b0;
      n_vec++; if (resp_fault !== 1'b1 || resp_instr !== 32'h0 || resp_halt !== 1'b0) begin n_err++; $display("FAIL fault_range got f=%b %h h=%b want 1 0 0", resp_fault, resp_instr, resp_halt); end
      n_vec++; if (fetch_count !== 16'd8) begin n_err++; $display("FAIL fault_count2 got %0d want 8", fetch_count); end
      step();
   endtask

   task automatic test_same_edge_write();
      req_valid = 1'b1;
      req_addr  = AW'(4);
      prog_we   = 1'b1;
      prog_addr = IW'(1);
      prog_data = 32'h0000_0013;
      step();
      prog_we = 1'b0;
      n_vec++; if (resp_instr !== 32'h0051_2023 || resp_fault !== 1'b0) begin n_err++; $display("FAIL rdfirst_old got %h f=%b want 00512023 0", resp_instr, resp_fault); end
      step();
      req_valid = 1'b0;
      n_vec++; if (resp_instr !== 32'h0000_0013 || fetch_count !== 16'd10) begin n_err++; $display("FAIL rdfirst_new got %h cnt=%0d want 00000013 10", resp_instr, fetch_count); end
      step();
   endtask

   task automatic test_reset_mid_transfer();
      req_valid = 1'b1;
      req_addr  = AW'(8);
      step();
      req_addr = '0;
      step();
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      n_vec++; if (halted !== 1'b1 || resp_valid !== 1'b1 || resp_instr !== 32'h3e80_0293) begin n_err++; $display("FAIL pre_reset got halted=%b v=%b %h want 1 1 3e800293", halted, resp_valid, resp_instr); end
      #2 reset_n = 1'b0;
      #1;
      n_vec++; if (resp_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0) begin n_err++; $display("FAIL async_reset got v=%b halted=%b cnt=%0d want 0 0 0", resp_valid, halted, fetch_count); end
      #2 reset_n = 1'b1;
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_addr   = '0;
      step();
      req_valid = 1'b0;
      n_vec++; if (resp_valid !== 1'b1 || resp_instr !== 32'h3e80_0293 || fetch_count !== 16'd1) begin n_err++; $display("FAIL retained got v=%b %h cnt=%0d want 1 3e800293 1", resp_valid, resp_instr, fetch_count); end
      step();
   endtask

   initial begin
      test_reset();
      test_program();
      test_fetch_halt();
      test_halted_resume();
      test_backpressure();
      test_faults();
      test_same_edge_write();
      test_reset_mid_transfer();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
